// File: rtl/eth_phy_10g_pkg.sv
// eth_phy_10g_pkg: shared sync header, lock window, descrambler and FSM definitions
package eth_phy_10g_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam int LOCK_WIN = 64;
  localparam int LOCK_ERR_MAX = 16;
  localparam int SCR_TAP_A = 39;
  localparam int SCR_TAP_B = 58;
  typedef enum logic [1:0] {UNLOCKED, LOCKED, SLIP} lock_state_t;
  function automatic logic sh_valid(input logic [1:0] hdr);
    return hdr == SYNC_DATA || hdr == SYNC_CTRL;
  endfunction
endpackage

// File: rtl/eth_phy_10g_rx_frame_sync.sv
// eth_phy_10g_rx_frame_sync: block-lock state machine driving the serdes bitslip request
module eth_phy_10g_rx_frame_sync
  import eth_phy_10g_pkg::*;
#(
  parameter int SLIP_WAIT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vld,
  input  logic [1:0] hdr,
  output logic       bitslip,
  output logic       block_lock,
  output logic       sh_err
);
  lock_state_t state;
  logic [6:0] sh_cnt;
  logic [4:0] sh_inv_cnt;
  logic [7:0] slip_cnt;
  logic valid;
  assign valid = sh_valid(hdr);
  assign sh_err = vld && !valid && state != SLIP;
  always_ff @(posedge clk) begin
    bitslip <= 1'b0;
    if (!rst_n) begin
      state <= UNLOCKED;
      sh_cnt <= '0;
      sh_inv_cnt <= '0;
      slip_cnt <= '0;
      block_lock <= 1'b0;
    end else if (vld) begin
      case (state)
        UNLOCKED: begin
          if (!valid) begin
            bitslip <= 1'b1;
            sh_cnt <= '0;
            slip_cnt <= '0;
            state <= SLIP;
          end else if (sh_cnt == 7'(LOCK_WIN - 1)) begin
            block_lock <= 1'b1;
            sh_cnt <= '0;
            sh_inv_cnt <= '0;
            state <= LOCKED;
          end else begin
            sh_cnt <= sh_cnt + 7'd1;
          end
        end
        LOCKED: begin
          if (!valid && sh_inv_cnt == 5'(LOCK_ERR_MAX - 1)) begin
            block_lock <= 1'b0;
            bitslip <= 1'b1;
            sh_cnt <= '0;
            sh_inv_cnt <= '0;
            slip_cnt <= '0;
            state <= SLIP;
          end else if (sh_cnt == 7'(LOCK_WIN - 1)) begin
            sh_cnt <= '0;
            sh_inv_cnt <= '0;
          end else begin
            sh_cnt <= sh_cnt + 7'd1;
            sh_inv_cnt <= sh_inv_cnt + 5'(!valid);
          end
        end
        default: begin
          if (slip_cnt == 8'(SLIP_WAIT - 1)) begin
            slip_cnt <= '0;
            sh_cnt <= '0;
            sh_inv_cnt <= '0;
            state <= UNLOCKED;
          end else begin
            slip_cnt <= slip_cnt + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/eth_phy_10g_rx_if.sv
// eth_phy_10g_rx_if: 10GBASE-R receive serdes interface with block lock and self-synchronous descrambler
module eth_phy_10g_rx_if
  import eth_phy_10g_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH = 2,
  parameter bit BIT_REVERSE = 0,
  parameter bit SCRAMBLER_DISABLE = 0,
  parameter bit SERDES_PIPELINE = 0,
  parameter int SLIP_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] serdes_rx_data,
  input  logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic                  serdes_rx_bitslip,
  output logic [DATA_WIDTH-1:0] encoded_rx_data,
  output logic [HDR_WIDTH-1:0]  encoded_rx_hdr,
  output logic                  rx_block_lock,
  output logic [15:0]           rx_sh_error_count
);
  if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_width
    $fatal(1, "eth_phy_10g_rx_if supports only DATA_WIDTH=64 and HDR_WIDTH=2");
  end
  logic [DATA_WIDTH-1:0] rev_data, in_data, s_data, descr;
  logic [HDR_WIDTH-1:0] rev_hdr, in_hdr, s_hdr;
  logic [SCR_TAP_B-1:0] scr_state;
  logic vld, sh_err;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_rev_data
    assign rev_data[i] = serdes_rx_data[DATA_WIDTH-1-i];
  end
  for (genvar i = 0; i < HDR_WIDTH; i++) begin : g_rev_hdr
    assign rev_hdr[i] = serdes_rx_hdr[HDR_WIDTH-1-i];
  end
  assign in_data = BIT_REVERSE ? rev_data : serdes_rx_data;
  assign in_hdr = BIT_REVERSE ? rev_hdr : serdes_rx_hdr;
  if (SERDES_PIPELINE) begin : g_pipe
    always_ff @(posedge clk) begin
      s_data <= in_data;
      s_hdr <= in_hdr;
      vld <= rst_n;
    end
  end else begin : g_direct
    assign s_data = in_data;
    assign s_hdr = in_hdr;
    assign vld = 1'b1;
  end
  assign descr = SCRAMBLER_DISABLE ? s_data :
    s_data ^ {s_data[DATA_WIDTH-SCR_TAP_A-1:0], scr_state[SCR_TAP_B-1:SCR_TAP_B-SCR_TAP_A]}
           ^ {s_data[DATA_WIDTH-SCR_TAP_B-1:0], scr_state};
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      encoded_rx_data <= '0;
      encoded_rx_hdr <= '0;
      scr_state <= '1;
      rx_sh_error_count <= '0;
    end else if (vld) begin
      encoded_rx_data <= descr;
      encoded_rx_hdr <= s_hdr;
      scr_state <= s_data[DATA_WIDTH-1 -: SCR_TAP_B];
      rx_sh_error_count <= rx_sh_error_count + 16'(sh_err && rx_sh_error_count != 16'hFFFF);
    end
  end
  eth_phy_10g_rx_frame_sync #(.SLIP_WAIT(SLIP_WAIT)) u_frame_sync (
    .clk(clk),
    .rst_n(rst_n),
    .vld(vld),
    .hdr(s_hdr),
    .bitslip(serdes_rx_bitslip),
    .block_lock(rx_block_lock),
    .sh_err(sh_err)
  );
endmodule

// File: tb/tb_eth_phy_10g_rx_if.sv
// tb_eth_phy_10g_rx_if: directed checks of lock, slip, error count and descrambling across parameter variants
module tb_eth_phy_10g_rx_if;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] d = '0, d_rev;
  logic [1:0] h = '0, h_rev;
  logic [63:0] m_data, n_data, r_data, p_data;
  logic [1:0] m_hdr, n_hdr, r_hdr, p_hdr;
  logic m_slip, n_slip, r_slip, p_slip;
  logic m_lock, n_lock, r_lock, p_lock;
  logic [15:0] m_cnt, n_cnt, r_cnt, p_cnt;
  int checks = 0;
  int errors = 0;
  int blk = 0;
  logic [57:0] tx_st = '0;
  logic [63:0] prev_pay = '0;
  logic [1:0] prev_h = '0;
  logic prev_lock = 1'b0, prev_slip = 1'b0;
  logic [15:0] prev_cnt = '0;
  always #5 clk = ~clk;
  always_comb begin
    d_rev = '0;
    for (int i = 0; i < 64; i++) d_rev[i] = d[63-i];
  end
  assign h_rev = {h[0], h[1]};
  eth_phy_10g_rx_if dut_m (.clk(clk), .rst_n(rst_n), .serdes_rx_data(d), .serdes_rx_hdr(h),
    .serdes_rx_bitslip(m_slip), .encoded_rx_data(m_data), .encoded_rx_hdr(m_hdr),
    .rx_block_lock(m_lock), .rx_sh_error_count(m_cnt));
  eth_phy_10g_rx_if #(.SCRAMBLER_DISABLE(1)) dut_n (.clk(clk), .rst_n(rst_n), .serdes_rx_data(d),
    .serdes_rx_hdr(h), .serdes_rx_bitslip(n_slip), .encoded_rx_data(n_data), .encoded_rx_hdr(n_hdr),
    .rx_block_lock(n_lock), .rx_sh_error_count(n_cnt));
  eth_phy_10g_rx_if #(.BIT_REVERSE(1)) dut_r (.clk(clk), .rst_n(rst_n), .serdes_rx_data(d_rev),
    .serdes_rx_hdr(h_rev), .serdes_rx_bitslip(r_slip), .encoded_rx_data(r_data), .encoded_rx_hdr(r_hdr),
    .rx_block_lock(r_lock), .rx_sh_error_count(r_cnt));
  eth_phy_10g_rx_if #(.SERDES_PIPELINE(1)) dut_p (.clk(clk), .rst_n(rst_n), .serdes_rx_data(d),
    .serdes_rx_hdr(h), .serdes_rx_bitslip(p_slip), .encoded_rx_data(p_data), .encoded_rx_hdr(p_hdr),
    .rx_block_lock(p_lock), .rx_sh_error_count(p_cnt));
  function automatic logic [63:0] rnd();
    return {$urandom, $urandom};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = rnd();
      h = 2'($urandom);
      @(posedge clk);
      #1;
      chk("rst_data", m_data, 64'd0);
      chk("rst_hdr", 64'(m_hdr), 64'd0);
      chk("rst_slip", 64'(m_slip), 64'd0);
      chk("rst_lock", 64'(m_lock), 64'd0);
      chk("rst_cnt", 64'(m_cnt), 64'd0);
      chk("rst_pp_data", p_data, 64'd0);
      chk("rst_pp_slip", 64'(p_slip), 64'd0);
      chk("rst_rv_lock", 64'(r_lock), 64'd0);
    end
    rst_n = 1'b1;
    blk = 0;
    prev_pay = '0;
    prev_h = '0;
    prev_lock = 1'b0;
    prev_slip = 1'b0;
    prev_cnt = '0;
  endtask
  task automatic step(input logic [63:0] pay, input logic [1:0] hh, input logic lk, input logic sl,
                      input logic [15:0] cn);
    logic [63:0] s;
    for (int k = 0; k < 64; k++) begin
      s[k] = pay[k] ^ tx_st[38] ^ tx_st[57];
      tx_st = {tx_st[56:0], s[k]};
    end
    d = s;
    h = hh;
    @(posedge clk);
    #1;
    blk++;
    chk("hdr", 64'(m_hdr), 64'(hh));
    chk("lock", 64'(m_lock), 64'(lk));
    chk("slip", 64'(m_slip), 64'(sl));
    chk("cnt", 64'(m_cnt), 64'(cn));
    chk("nd_data", n_data, s);
    chk("nd_hdr", 64'(n_hdr), 64'(hh));
    chk("nd_lock", 64'(n_lock), 64'(lk));
    chk("nd_slip", 64'(n_slip), 64'(sl));
    chk("nd_cnt", 64'(n_cnt), 64'(cn));
    chk("rv_hdr", 64'(r_hdr), 64'(hh));
    chk("rv_lock", 64'(r_lock), 64'(lk));
    chk("rv_slip", 64'(r_slip), 64'(sl));
    chk("rv_cnt", 64'(r_cnt), 64'(cn));
    chk("pp_hdr", 64'(p_hdr), 64'(prev_h));
    chk("pp_lock", 64'(p_lock), 64'(prev_lock));
    chk("pp_slip", 64'(p_slip), 64'(prev_slip));
    chk("pp_cnt", 64'(p_cnt), 64'(prev_cnt));
    if (blk >= 2) begin
      chk("data", m_data, pay);
      chk("rv_data", r_data, pay);
    end
    if (blk >= 3) chk("pp_data", p_data, prev_pay);
    prev_pay = pay;
    prev_h = hh;
    prev_lock = lk;
    prev_slip = sl;
    prev_cnt = cn;
  endtask
  initial begin
    do_reset(4);
    for (int i = 1; i <= 64; i++) step(rnd(), 2'b01, i == 64, 1'b0, 16'd0);
    for (int i = 1; i <= 64; i++)
      step(rnd(), i <= 15 ? ((i % 2) ? 2'b00 : 2'b11) : 2'b10, 1'b1, 1'b0, 16'(i <= 15 ? i : 15));
    for (int i = 1; i <= 16; i++) step(rnd(), 2'b11, i < 16, i == 16, 16'(15 + i));
    for (int i = 1; i <= 8; i++) step(rnd(), 2'b11, 1'b0, 1'b0, 16'd31);
    for (int i = 1; i <= 9; i++) step(rnd(), 2'b01, 1'b0, 1'b0, 16'd31);
    step(rnd(), 2'b00, 1'b0, 1'b1, 16'd32);
    for (int i = 1; i <= 8; i++) step(rnd(), 2'b11, 1'b0, 1'b0, 16'd32);
    for (int i = 1; i <= 64; i++) step(rnd(), 2'b01, i == 64, 1'b0, 16'd32);
    for (int i = 1; i <= 64; i++)
      step(rnd(), i > 48 ? 2'b00 : 2'b01, i < 64, i == 64, 16'(32 + (i > 48 ? i - 48 : 0)));
    for (int i = 1; i <= 8; i++) step(rnd(), 2'b10, 1'b0, 1'b0, 16'd48);
    for (int i = 1; i <= 64; i++) step(rnd(), 2'b01, i == 64, 1'b0, 16'd48);
    for (int i = 1; i <= 8; i++) step(64'h000000000000001E, 2'b10, 1'b1, 1'b0, 16'd48);
    do_reset(2);
    step(rnd(), 2'b00, 1'b0, 1'b1, 16'd1);
    step(rnd(), 2'b11, 1'b0, 1'b0, 16'd1);
    step(rnd(), 2'b11, 1'b0, 1'b0, 16'd1);
    do_reset(1);
    for (int i = 1; i <= 64; i++) step(64'h000000000000001E, 2'b10, i == 64, 1'b0, 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
